// File: rtl/hex_scan_display_if.sv
// Bus bundle for hex_scan_display: value/dp load side plus segment, digit and pulse outputs.
interface hex_scan_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      blank;
  logic [6:0]                seg;
  logic                      dp;
  logic [NUM_DIGITS-1:0]     dig_sel;
  logic                      frame_done;
  logic                      upd_done;

  modport master (
    output load, value, dp_in, blank,
    input  seg, dp, dig_sel, frame_done, upd_done
  );

  modport slave (
    input  load, value, dp_in, blank,
    output seg, dp, dig_sel, frame_done, upd_done
  );
endinterface

// File: rtl/hex_scan_display.sv
// Time-multiplexed N-digit 7-segment hex driver with frame-boundary shadow commit.
// Optional leading-zero blanking when HEX_SCAN_LZB_EN is defined.
module hex_scan_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  hex_scan_display_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic       DP_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow, disp;
  logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp;
  logic                    pending;

  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   dig_q;
  logic                    frame_q, upd_q;

  logic                    slot_end, frame_end;
  logic [3:0]              nib;
  logic                    cur_dp;
  logic [NUM_DIGITS-1:0]   sel;
  logic                    shown;
  logic [6:0]              seg_n;
  logic                    dp_n;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] g;
    g = '0;
    case (n)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  4'hF: g = 7'h71;
      default: g = '0;
    endcase
    return g;
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  always_comb begin
    nib    = '0;
    cur_dp = 1'b0;
    sel    = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib    = disp[4*k +: 4];
        cur_dp = disp_dp[k];
        sel[k] = 1'b1;
      end
    end
  end

`ifdef HEX_SCAN_LZB_EN
  logic [IW-1:0] msd;
  // Highest nonzero nibble; stays 0 for an all-zero value so digit 0 always shows.
  always_comb begin
    msd = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (disp[4*k +: 4] != 4'h0) msd = IW'(k);
    end
  end
  assign shown = (idx <= msd);
`else
  assign shown = 1'b1;
`endif

  assign seg_n = (bus.blank || !shown) ? 7'h00 : decode(nib);
  assign dp_n  = bus.blank ? 1'b0 : cur_dp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      pending   <= 1'b0;
      disp      <= '0;
      disp_dp   <= '0;
      seg_q     <= SEG_INV;
      dp_q      <= DP_INV;
      dig_q     <= DIG_INV;
      frame_q   <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

      frame_q <= frame_end;
      upd_q   <= frame_end && (pending || bus.load);

      // A load on the boundary cycle bypasses the shadow straight into the display.
      if (frame_end) begin
        if (bus.load) begin
          disp    <= bus.value;
          disp_dp <= bus.dp_in;
        end else if (pending) begin
          disp    <= shadow;
          disp_dp <= shadow_dp;
        end
        pending <= 1'b0;
      end else if (bus.load) begin
        shadow    <= bus.value;
        shadow_dp <= bus.dp_in;
        pending   <= 1'b1;
      end

      seg_q <= seg_n ^ SEG_INV;
      dp_q  <= dp_n ^ DP_INV;
      dig_q <= (slot_end ? '0 : sel) ^ DIG_INV;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.dig_sel    = dig_q;
  assign bus.frame_done = frame_q;
  assign bus.upd_done   = upd_q;
endmodule

// File: doc/hex_scan_display.md
# hex_scan_display

Time-multiplexed driver for an N-digit common-cathode/common-anode 7-segment hex display. It accepts a `4*NUM_DIGITS`-bit value through a load strobe and holds it in a shadow register. The shadow is committed to the display register only at frame boundaries, so a digit never shows a partially updated value. The block scans one digit at a time, decodes the nibble to segments, and drives one-hot digit enables. It sits between any value-producing logic (counters, debug registers) and the board's segment/digit pins.

## Interface
- `NUM_DIGITS`, 4: digits scanned; legal range 1..16.
- `REFRESH_DIV`, 50000: clock cycles per digit slot; must be ≥ 2.
- `SEG_ACTIVE_LOW`, 0: 1 inverts `seg` and `dp` (segment lit = 0).
- `DIG_ACTIVE_LOW`, 0: 1 inverts `dig_sel` (digit enabled = 0).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `load`  in  1  strobe; captures `value`/`dp_in` into shadow this cycle.
- `value`  in  4*NUM_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k; digit 0 is least significant.
- `dp_in`  in  NUM_DIGITS  decimal point per digit, captured with `value`.
- `blank`  in  1  level; forces all segments and dp off while high (scan continues).
- `seg`  out  7  segments; bit0=a top, 1=b upper-right, 2=c lower-right, 3=d bottom, 4=e lower-left, 5=f upper-left, 6=g middle.
- `dp`  out  1  decimal point of the active digit.
- `dig_sel`  out  NUM_DIGITS  one-hot digit enable.
- `frame_done`  out  1  one-cycle pulse at the end of each full scan.
- `upd_done`  out  1  one-cycle pulse when a pending shadow value is committed.

## Operation
- State: slot counter `cnt` (0..REFRESH_DIV-1), digit index `idx` (0..NUM_DIGITS-1), shadow register and pending flag, display register.
- Each cycle `cnt` increments. At `cnt==REFRESH_DIV-1`, `cnt` wraps to 0 and `idx` advances. `idx` wraps from NUM_DIGITS-1 to 0.
- **Frame boundary:** cycle with `cnt==REFRESH_DIV-1` and `idx==NUM_DIGITS-1`. On that cycle:
  - `frame_done` is asserted next cycle.
  - If pending, or if `load` is high, the display register is loaded and pending clears. The source is `value`/`dp_in` directly when `load` is high that cycle (bypass); otherwise it is the shadow. `upd_done` is asserted next cycle.
- **`load` on any other cycle:** shadow ← `value`/`dp_in`; pending ← 1. A later load before commit overwrites the shadow (last write wins; only one `upd_done` per commit).
- **Decode (polarity-neutral, hex):** 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
- **Anti-ghosting:** `dig_sel` is all-inactive during the cycle following `cnt==REFRESH_DIV-1`, i.e. the first output cycle of each slot.
- **`blank`:** `seg` = 0x00 and `dp` = 0 (neutral), then polarity is applied. `dig_sel` is unaffected.

## Timing
- All outputs are registered. Outputs in cycle t+1 reflect `cnt`/`idx`/display register in cycle t.
- **Reset (`rst_n` low at an edge):**
  - `cnt`=0, `idx`=0, shadow=0, pending=0, display=0.
  - `seg`, `dp`, `dig_sel` at inactive levels (all segments and digits off, per polarity parameters).
  - `frame_done`=0, `upd_done`=0.
- **First cycle after release:** outputs show digit 0 of display=0, i.e. the "0" pattern with dig_sel bit0 active.
- **Reset mid-scan or with a pending load:** the pending value is discarded, and no `upd_done` is issued.
- **Load-to-display latency:** at most NUM_DIGITS*REFRESH_DIV+1 cycles. The committed value first appears on digit 0 in the cycle after `upd_done`.
- **Frame period:** exactly NUM_DIGITS*REFRESH_DIV cycles between `frame_done` pulses.
- **NUM_DIGITS=1:** every slot end is a frame boundary; `idx` stays 0.

## Configuration
- **`HEX_SCAN_LZB_EN` defined:** leading-zero blanking.
  - Digits above the most significant nonzero nibble of the display register output segments 0x00 (neutral).
  - Digit 0 is always shown, so value 0 displays a single "0".
  - `dp` and `dig_sel` are still driven normally.
- **`HEX_SCAN_LZB_EN` undefined:** every digit is decoded, including leading zeros.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, both polarity parameters 0, unless stated.
- **Reset:** hold `rst_n`=0 for 3 cycles → `seg`=0, `dig_sel`=0, pulses 0. First cycle after release → `seg`=0x3F, `dig_sel`=0001.
- **Scan order:** with display 0x1234 → `dig_sel` sequence is 0000 (ghost cycle), 0001×3, then 0000, 0010×3, and so on. Digit 0 shows `seg`=0x66, digit 3 shows 0x06. `frame_done` pulses every 16 cycles.
- **Shadowed update:** `load` 0xABCD mid-frame, then `load` 0xC0DE before the boundary → one `upd_done`. The next frame shows E, d, 0, C (0x79, 0x5E, 0x3F, 0x39).
- **Load on boundary cycle:** `load` 0x00F0 exactly at `cnt`=3, `idx`=3 → `upd_done` next cycle, and digit 1 shows 0x71 in that same frame.
- **Blank and polarity:** `blank`=1 → `seg`=0, scan unchanged. With SEG_ACTIVE_LOW=1 and DIG_ACTIVE_LOW=1, the reset outputs are `seg`=0x7F and `dig_sel`=1111.
- **LZB:** with `HEX_SCAN_LZB_EN` defined and display 0x0050 → digits 3 and 2 show `seg`=0x00. Display 0x0000 → digit 0 shows 0x3F and the others show 0x00.
